// File: rtl/bcd_score_counter.sv
// bcd_score_counter
//   Packed-BCD score register with clear, load and weighted increment/decrement.
//   Inc/dec use the weight 10^digit_sel with full decimal carry/borrow. Results
//   clip to all 9s (inc) or 0 (dec), and sat reports the clip. Status strobes
//   are registered, so they appear in the cycle after the sampling edge.
//
//   Request handshake: requests are level-sampled on every rising clk edge.
//   There is no ready/busy signal. A request held high for N edges counts as
//   N requests. Priority: clear > load > inc/dec.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   set score to 0
//   load       in   load load_value (rejected with err if any digit > 9)
//   load_value in   [4*DIGITS-1:0] BCD value, digit 0 (ones) in [3:0]
//   inc        in   add 10^digit_sel
//   dec        in   subtract 10^digit_sel
//   digit_sel  in   [SW-1:0] weight exponent (>= DIGITS is rejected with err)
//   score      out  [4*DIGITS-1:0] registered BCD score
//   at_max     out  score is all 9s
//   at_min     out  score is 0
//   upd        out  one-cycle strobe: score changed on the previous edge
//   sat        out  one-cycle strobe: previous inc/dec was clipped
//   err        out  one-cycle strobe: previous request was illegal
module bcd_score_counter #(
    parameter int DIGITS = 3,
    parameter int SW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  inc,
    input  logic                  dec,
    input  logic [SW-1:0]         digit_sel,
    output logic [4*DIGITS-1:0]   score,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  upd,
    output logic                  sat,
    output logic                  err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic                upd_q, upd_d;
    logic                sat_q, sat_d;
    logic                err_q, err_d;

    logic [4*DIGITS-1:0] inc_res;
    logic                inc_ovf;
    logic [4*DIGITS-1:0] dec_res;
    logic                dec_unf;
    logic                load_ok;
    logic                sel_ok;

    assign sel_ok = (int'(digit_sel) < DIGITS);

    // Every load digit must be a legal BCD digit.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Add 10^digit_sel: digits below the selected one pass through, the
    // selected digit takes the +1, and the carry ripples upward.
    always_comb begin : inc_calc
        logic       carry;
        logic [3:0] d;
        carry   = 1'b0;
        d       = 4'd0;
        inc_res = score_q;
        for (int i = 0; i < DIGITS; i++) begin
            d = score_q[4*i +: 4];
            if (i == int'(digit_sel)) begin
                carry = 1'b1;
            end
            if (carry) begin
                if (d == 4'd9) begin
                    d     = 4'd0;
                    carry = 1'b1;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            inc_res[4*i +: 4] = d;
        end
        inc_ovf = carry;
    end

    // Subtract 10^digit_sel with decimal borrow. A borrow out of the top
    // digit means score < 10^digit_sel.
    always_comb begin : dec_calc
        logic       borrow;
        logic [3:0] d;
        borrow  = 1'b0;
        d       = 4'd0;
        dec_res = score_q;
        for (int i = 0; i < DIGITS; i++) begin
            d = score_q[4*i +: 4];
            if (i == int'(digit_sel)) begin
                borrow = 1'b1;
            end
            if (borrow) begin
                if (d == 4'd0) begin
                    d      = 4'd9;
                    borrow = 1'b1;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            dec_res[4*i +: 4] = d;
        end
        dec_unf = borrow;
    end

    // Request decode and next-state logic.
    always_comb begin
        score_d = score_q;
        sat_d   = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            score_d = '0;
        end else if (load) begin
            if (load_ok) begin
                score_d = load_value;
            end else begin
                err_d = 1'b1;
            end
        end else if (inc && dec) begin
            // Opposing requests cancel. This takes priority over the
            // digit_sel legality check.
            score_d = score_q;
        end else if (inc || dec) begin
            if (!sel_ok) begin
                err_d = 1'b1;
            end else if (inc) begin
                if (inc_ovf) begin
                    score_d = ALL_NINES;
                    sat_d   = 1'b1;
                end else begin
                    score_d = inc_res;
                end
            end else begin
                if (dec_unf) begin
                    score_d = '0;
                    sat_d   = 1'b1;
                end else begin
                    score_d = dec_res;
                end
            end
        end
        upd_d = (score_d != score_q);

        state_d = ST_IDLE;
        if (upd_d || sat_d || err_d) begin
            state_d = ST_REPORT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            upd_q   <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            upd_q   <= upd_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    // Strobes are visible only while the FSM is in REPORT.
    assign score  = score_q;
    assign at_max = (score_q == ALL_NINES);
    assign at_min = (score_q == '0);
    assign upd    = (state_q == ST_REPORT) && upd_q;
    assign sat    = (state_q == ST_REPORT) && sat_q;
    assign err    = (state_q == ST_REPORT) && err_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
module tb_bcd_score_counter;

  localparam int DIGITS = 3;
  localparam int SW     = 2;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              load;
  logic [11:0]       load_value;
  logic              inc;
  logic              dec;
  logic [SW-1:0]     digit_sel;
  logic [11:0]       score;
  logic              at_max;
  logic              at_min;
  logic              upd;
  logic              sat;
  logic              err;

  int errors = 0;
  int checks = 0;

  bcd_score_counter #(.DIGITS(DIGITS), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .inc        (inc),
    .dec        (dec),
    .digit_sel  (digit_sel),
    .score      (score),
    .at_max     (at_max),
    .at_min     (at_min),
    .upd        (upd),
    .sat        (sat),
    .err        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one request, take one edge, sample 1 time unit later, go idle
  task automatic do_req(input logic c, input logic l, input logic [11:0] lv,
                        input logic i, input logic d, input logic [SW-1:0] sel);
    clear = c; load = l; load_value = lv; inc = i; dec = d; digit_sel = sel;
    @(posedge clk);
    #1;
    clear = 0; load = 0; load_value = '0; inc = 0; dec = 0; digit_sel = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 0; load = 0; load_value = '0; inc = 0; dec = 0; digit_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (score !== 12'h000) begin errors++; $display("FAIL reset_score got=%h exp=000", score); end
    checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL reset_at_min got=%b exp=1", at_min); end
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got=%b exp=0", at_max); end
    checks++; if ({upd, sat, err} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {upd, sat, err}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_inc_ten();
    logic [11:0] exp_s;
    for (int k = 1; k <= 10; k++) begin
      do_req(0, 0, '0, 1, 0, 2'd0);
      exp_s = (k == 10) ? 12'h010 : 12'(k);
      checks++; if (score !== exp_s) begin errors++; $display("FAIL inc_ten_score step=%0d got=%h exp=%h", k, score, exp_s); end
      checks++; if (upd !== 1'b1) begin errors++; $display("FAIL inc_ten_upd step=%0d got=%b exp=1", k, upd); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL inc_ten_sat step=%0d got=%b exp=0", k, sat); end
    end
    // idle cycle: strobe drops after one cycle
    @(posedge clk); #1;
    checks++; if ({upd, sat, err} !== 3'b000) begin errors++; $display("FAIL idle_strobes got=%b exp=000", {upd, sat, err}); end
  endtask

  task automatic test_saturate();
    do_req(0, 1, 12'h995, 0, 0, 2'd0);
    checks++; if (score !== 12'h995) begin errors++; $display("FAIL sat_load got=%h exp=995", score); end
    do_req(0, 0, '0, 1, 0, 2'd1);
    checks++; if (score !== 12'h999) begin errors++; $display("FAIL sat_clip_score got=%h exp=999", score); end
    checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL sat_at_max got=%b exp=1", at_max); end
    checks++; if ({upd, sat, err} !== 3'b110) begin errors++; $display("FAIL sat_clip_strobes got=%b exp=110", {upd, sat, err}); end
    do_req(0, 0, '0, 1, 0, 2'd0);
    checks++; if (score !== 12'h999) begin errors++; $display("FAIL sat_hold_score got=%h exp=999", score); end
    checks++; if ({upd, sat, err} !== 3'b010) begin errors++; $display("FAIL sat_hold_strobes got=%b exp=010", {upd, sat, err}); end
  endtask

  task automatic test_carry_borrow();
    do_req(0, 1, 12'h099, 0, 0, 2'd0);
    do_req(0, 0, '0, 1, 0, 2'd0);
    checks++; if (score !== 12'h100) begin errors++; $display("FAIL carry_score got=%h exp=100", score); end
    do_req(0, 0, '0, 0, 1, 2'd0);
    checks++; if (score !== 12'h099) begin errors++; $display("FAIL borrow_score got=%h exp=099", score); end
    checks++; if ({upd, sat, err} !== 3'b100) begin errors++; $display("FAIL borrow_strobes got=%b exp=100", {upd, sat, err}); end
  endtask

  task automatic test_dec();
    do_req(0, 1, 12'h105, 0, 0, 2'd0);
    do_req(0, 0, '0, 0, 1, 2'd1);
    checks++; if (score !== 12'h095) begin errors++; $display("FAIL dec_tens got=%h exp=095", score); end
    checks++; if ({upd, sat, err} !== 3'b100) begin errors++; $display("FAIL dec_tens_strobes got=%b exp=100", {upd, sat, err}); end
    do_req(0, 0, '0, 0, 1, 2'd2);
    checks++; if (score !== 12'h000) begin errors++; $display("FAIL dec_clip_score got=%h exp=000", score); end
    checks++; if ({upd, sat, err} !== 3'b110) begin errors++; $display("FAIL dec_clip_strobes got=%b exp=110", {upd, sat, err}); end
    checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL dec_at_min got=%b exp=1", at_min); end
    do_req(0, 0, '0, 0, 1, 2'd0);
    checks++; if ({score, upd, sat} !== {12'h000, 2'b01}) begin errors++; $display("FAIL dec_at_min_hold got=%h/%b%b exp=000/01", score, upd, sat); end
  endtask

  task automatic test_err();
    do_req(0, 1, 12'h250, 0, 0, 2'd0);
    do_req(0, 1, 12'h1A3, 0, 0, 2'd0);
    checks++; if (score !== 12'h250) begin errors++; $display("FAIL err_load_score got=%h exp=250", score); end
    checks++; if ({upd, sat, err} !== 3'b001) begin errors++; $display("FAIL err_load_strobes got=%b exp=001", {upd, sat, err}); end
    do_req(0, 0, '0, 1, 0, 2'd3);
    checks++; if (score !== 12'h250) begin errors++; $display("FAIL err_sel_score got=%h exp=250", score); end
    checks++; if ({upd, sat, err} !== 3'b001) begin errors++; $display("FAIL err_sel_strobes got=%b exp=001", {upd, sat, err}); end
  endtask

  task automatic test_priority();
    do_req(0, 1, 12'h042, 0, 0, 2'd0);
    do_req(1, 1, 12'h777, 1, 0, 2'd0);
    checks++; if (score !== 12'h000) begin errors++; $display("FAIL prio_clear_score got=%h exp=000", score); end
    checks++; if ({upd, sat, err} !== 3'b100) begin errors++; $display("FAIL prio_clear_strobes got=%b exp=100", {upd, sat, err}); end
    do_req(1, 0, '0, 0, 0, 2'd0);
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL clear_at_zero_upd got=%b exp=0", upd); end
    do_req(0, 1, 12'h042, 0, 0, 2'd0);
    do_req(0, 0, '0, 1, 1, 2'd1);
    checks++; if (score !== 12'h042) begin errors++; $display("FAIL incdec_score got=%h exp=042", score); end
    checks++; if ({upd, sat, err} !== 3'b000) begin errors++; $display("FAIL incdec_strobes got=%b exp=000", {upd, sat, err}); end
  endtask

  task automatic test_async_reset();
    do_req(0, 0, '0, 1, 0, 2'd0);
    checks++; if ({score, upd} !== {12'h043, 1'b1}) begin errors++; $display("FAIL ar_pre got=%h/%b exp=043/1", score, upd); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (score !== 12'h000) begin errors++; $display("FAIL ar_async_score got=%h exp=000", score); end
    checks++; if ({upd, at_min} !== 2'b01) begin errors++; $display("FAIL ar_async_flags got=%b exp=01", {upd, at_min}); end
    inc = 1'b1;
    @(posedge clk); #1;
    checks++; if (score !== 12'h000) begin errors++; $display("FAIL ar_discard got=%h exp=000", score); end
    @(negedge clk);
    rst = 1'b0;
    inc = 1'b0;
    @(posedge clk); #1;
    checks++; if ({score, upd, sat, err} !== {12'h000, 3'b000}) begin errors++; $display("FAIL ar_release got=%h/%b exp=000/000", score, {upd, sat, err}); end
  endtask

  initial begin
    test_reset();
    test_inc_ten();
    test_saturate();
    test_carry_borrow();
    test_dec();
    test_err();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
